// File: rtl/cluster_locate_multi.sv
`default_nettype none
//==============================================================================
// Module   : cluster_locate_multi
// Brief    : Finds up to MAX_CL above-threshold channel runs in one Avalon-ST
//            frame and streams one record per stored cluster plus a summary.
// Revision : 1.0  initial release
//==============================================================================
module cluster_locate_multi #(
    parameter int DATA_W = 16,
    parameter int CH_NUM = 320,
    parameter int CH_W   = 9,
    parameter int MAX_CL = 4,
    parameter int SUM_W  = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in_data,
    input  logic              data_in_valid,
    output logic              data_in_ready,
    input  logic              data_in_startofpacket,
    input  logic              data_in_endofpacket,
    input  logic [DATA_W-1:0] threshold,
    input  logic [CH_W-1:0]   min_size,
    output logic              cl_valid,
    input  logic              cl_ready,
    output logic [CH_W-1:0]   cl_left,
    output logic [CH_W-1:0]   cl_right,
    output logic [SUM_W-1:0]  cl_sum,
    output logic [3:0]        cl_index,
    output logic              cl_last,
    output logic              frame_done,
    output logic [4:0]        n_clusters,
    output logic              cl_overflow,
    output logic              frame_err
);

    localparam int            CL_AW     = (MAX_CL > 1) ? $clog2(MAX_CL) : 1;
    localparam logic [CH_W:0] CNT_SAT   = {(CH_W+1){1'b1}};
    localparam logic [CH_W:0] CH_SAT    = {1'b0, {CH_W{1'b1}}};
    localparam logic [CH_W:0] FRAME_LEN = (CH_W+1)'(CH_NUM);
    localparam logic [4:0]    MAX_CL_N  = 5'(MAX_CL);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REC  = 2'd1,
        S_EMIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic                     ready_q, ready_d;
    logic [CH_W:0]            cnt_q, cnt_d;
    logic signed [DATA_W-1:0] thr_q, thr_d;
    logic [CH_W-1:0]          min_q, min_d;
    logic                     open_q, open_d;
    logic [CH_W-1:0]          rleft_q, rleft_d;
    logic [CH_W-1:0]          rlen_q, rlen_d;
    logic signed [SUM_W-1:0]  rsum_q, rsum_d;
    logic [4:0]               ncl_q, ncl_d;
    logic                     ovf_q, ovf_d;
    logic                     err_q, err_d;
    logic [3:0]               idx_q, idx_d;

    logic [CH_W-1:0]          st_left_q  [MAX_CL];
    logic [CH_W-1:0]          st_right_q [MAX_CL];
    logic signed [SUM_W-1:0]  st_sum_q   [MAX_CL];

    logic                     st_we;
    logic [CL_AW-1:0]         st_waddr;
    logic [CH_W-1:0]          st_wleft, st_wright;
    logic signed [SUM_W-1:0]  st_wsum;

    logic                     beat, cls;
    logic [CH_W-1:0]          cls_left, cls_right, cls_len;
    logic signed [SUM_W-1:0]  cls_sum;

    logic                     accept, sop, above, last_rec;
    logic [CH_W-1:0]          ch_cur, min_raw, min_eff;
    logic signed [DATA_W-1:0] thr_eff;
    logic signed [SUM_W-1:0]  data_ext;
    logic [CL_AW-1:0]         rd;

    assign accept   = data_in_valid & ready_q;
    assign sop      = data_in_startofpacket;
    assign ch_cur   = sop ? '0 : ((cnt_q > CH_SAT) ? {CH_W{1'b1}} : cnt_q[CH_W-1:0]);
    assign thr_eff  = sop ? $signed(threshold) : thr_q;
    assign min_raw  = sop ? min_size : min_q;
    assign min_eff  = (min_raw == '0) ? CH_W'(1) : min_raw;
    assign above    = $signed(data_in_data) > thr_eff;
    assign data_ext = SUM_W'($signed(data_in_data));
    assign last_rec = ({1'b0, idx_q} == (ncl_q - 5'd1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        thr_d     = thr_q;
        min_d     = min_q;
        open_d    = open_q;
        rleft_d   = rleft_q;
        rlen_d    = rlen_q;
        rsum_d    = rsum_q;
        ncl_d     = ncl_q;
        ovf_d     = ovf_q;
        err_d     = err_q;
        idx_d     = idx_q;
        st_we     = 1'b0;
        st_waddr  = '0;
        st_wleft  = '0;
        st_wright = '0;
        st_wsum   = '0;
        beat      = 1'b0;
        cls       = 1'b0;
        cls_left  = rleft_q;
        cls_right = '0;
        cls_len   = rlen_q;
        cls_sum   = rsum_q;

        case (state_q)
            S_IDLE: beat = accept & sop;
            S_REC:  beat = accept;
            S_EMIT: begin
                if (cl_ready) begin
                    if (last_rec) state_d = S_DONE;
                    else          idx_d   = idx_q + 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (beat) begin
            // A SOP restarts the frame; a SOP seen while recording is a fault.
            if (sop) begin
                thr_d  = $signed(threshold);
                min_d  = min_size;
                ncl_d  = '0;
                ovf_d  = 1'b0;
                err_d  = (state_q == S_REC);
                open_d = 1'b0;
                cnt_d  = '0;
            end

            if (above) begin
                if (open_d) begin
                    rlen_d = (rlen_q == {CH_W{1'b1}}) ? rlen_q : rlen_q + CH_W'(1);
                    rsum_d = rsum_q + data_ext;
                end else begin
                    open_d  = 1'b1;
                    rleft_d = ch_cur;
                    rlen_d  = CH_W'(1);
                    rsum_d  = data_ext;
                end
            end else begin
                if (open_d) begin
                    cls       = 1'b1;
                    cls_right = ch_cur - CH_W'(1);
                end
                open_d = 1'b0;
            end

            if (data_in_endofpacket && open_d) begin
                cls       = 1'b1;
                cls_left  = rleft_d;
                cls_right = ch_cur;
                cls_len   = rlen_d;
                cls_sum   = rsum_d;
                open_d    = 1'b0;
            end

            if (cls && (cls_len >= min_eff)) begin
                if (ncl_d < MAX_CL_N) begin
                    st_we     = 1'b1;
                    st_waddr  = ncl_d[CL_AW-1:0];
                    st_wleft  = cls_left;
                    st_wright = cls_right;
                    st_wsum   = cls_sum;
                    ncl_d     = ncl_d + 5'd1;
                end else begin
                    ovf_d = 1'b1;
                end
            end

            cnt_d = (cnt_d == CNT_SAT) ? cnt_d : cnt_d + (CH_W+1)'(1);

            if (data_in_endofpacket) begin
                err_d   = err_d | (cnt_d != FRAME_LEN);
                idx_d   = '0;
                state_d = (ncl_d != 5'd0) ? S_EMIT : S_DONE;
            end else begin
                state_d = S_REC;
            end
        end

        ready_d = (state_d == S_IDLE) || (state_d == S_REC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            cnt_q   <= '0;
            thr_q   <= '0;
            min_q   <= '0;
            open_q  <= 1'b0;
            rleft_q <= '0;
            rlen_q  <= '0;
            rsum_q  <= '0;
            ncl_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
            thr_q   <= thr_d;
            min_q   <= min_d;
            open_q  <= open_d;
            rleft_q <= rleft_d;
            rlen_q  <= rlen_d;
            rsum_q  <= rsum_d;
            ncl_q   <= ncl_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_CL; i++) begin
                st_left_q[i]  <= '0;
                st_right_q[i] <= '0;
                st_sum_q[i]   <= '0;
            end
        end else if (st_we) begin
            st_left_q[st_waddr]  <= st_wleft;
            st_right_q[st_waddr] <= st_wright;
            st_sum_q[st_waddr]   <= st_wsum;
        end
    end

    // Record fields read zero outside EMIT so idle outputs stay quiet.
    assign rd            = idx_q[CL_AW-1:0];
    assign data_in_ready = ready_q;
    assign cl_valid      = (state_q == S_EMIT);
    assign cl_left       = cl_valid ? st_left_q[rd]  : '0;
    assign cl_right      = cl_valid ? st_right_q[rd] : '0;
    assign cl_sum        = cl_valid ? st_sum_q[rd]   : '0;
    assign cl_index      = cl_valid ? idx_q          : '0;
    assign cl_last       = cl_valid & last_rec;
    assign frame_done    = (state_q == S_DONE);
    assign n_clusters    = ncl_q;
    assign cl_overflow   = ovf_q;
    assign frame_err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cluster_locate_multi.sv
`default_nettype none
//==============================================================================
// Module   : tb_cluster_locate_multi
// Brief    : Directed and random frames checked against a run-scan model.
// Revision : 1.0  initial release
//==============================================================================
module tb_cluster_locate_multi;
    localparam int DATA_W = 16;
    localparam int CH_NUM = 320;
    localparam int CH_W   = 9;
    localparam int MAX_CL = 4;
    localparam int SUM_W  = 25;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] data_in_data;
    logic              data_in_valid, data_in_ready;
    logic              data_in_startofpacket, data_in_endofpacket;
    logic [DATA_W-1:0] threshold;
    logic [CH_W-1:0]   min_size;
    logic              cl_valid, cl_ready, cl_last, frame_done;
    logic [CH_W-1:0]   cl_left, cl_right;
    logic [SUM_W-1:0]  cl_sum;
    logic [3:0]        cl_index;
    logic [4:0]        n_clusters;
    logic              cl_overflow, frame_err;

    always #5 clk = ~clk;

    cluster_locate_multi #(
        .DATA_W(DATA_W), .CH_NUM(CH_NUM), .CH_W(CH_W), .MAX_CL(MAX_CL), .SUM_W(SUM_W)
    ) dut (
        .clk(clk), .rst(rst),
        .data_in_data(data_in_data), .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .data_in_startofpacket(data_in_startofpacket),
        .data_in_endofpacket(data_in_endofpacket),
        .threshold(threshold), .min_size(min_size),
        .cl_valid(cl_valid), .cl_ready(cl_ready),
        .cl_left(cl_left), .cl_right(cl_right), .cl_sum(cl_sum),
        .cl_index(cl_index), .cl_last(cl_last), .frame_done(frame_done),
        .n_clusters(n_clusters), .cl_overflow(cl_overflow), .frame_err(frame_err)
    );

    int checks = 0;
    int errors = 0;
    int smp [0:511];
    int exp_n;
    bit exp_ovf, exp_err;
    int exp_l [0:MAX_CL-1];
    int exp_r [0:MAX_CL-1];
    int exp_s [0:MAX_CL-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] sum_bits(input int s);
        return 32'(s) & 32'h01FF_FFFF;
    endfunction

    // Reference: scan the frame for maximal runs strictly above threshold.
    task automatic model(input int n, input int thr, input int minsz, input bit pre_err);
        int m, i, j, s;
        exp_n   = 0;
        exp_ovf = 1'b0;
        exp_err = pre_err || (n != CH_NUM);
        m = (minsz == 0) ? 1 : minsz;
        i = 0;
        while (i < n) begin
            if (smp[i] > thr) begin
                j = i;
                s = 0;
                while (j < n && smp[j] > thr) begin
                    s += smp[j];
                    j++;
                end
                if (j - i >= m) begin
                    if (exp_n < MAX_CL) begin
                        exp_l[exp_n] = i;
                        exp_r[exp_n] = j - 1;
                        exp_s[exp_n] = s;
                        exp_n++;
                    end else begin
                        exp_ovf = 1'b1;
                    end
                end
                i = j;
            end else begin
                i++;
            end
        end
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < 512; i++) smp[i] = v;
    endtask

    task automatic beat(input int d, input bit s, input bit e);
        int t;
        t = 0;
        @(negedge clk);
        data_in_valid         = 1'b1;
        data_in_data          = d[15:0];
        data_in_startofpacket = s;
        data_in_endofpacket   = e;
        while (data_in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) chk("beat_ready_timeout", 32'(data_in_ready), 32'd1);
    endtask

    task automatic send_frame(input int n, input int pre);
        for (int p = 0; p < pre; p++) beat((p >= 20 && p <= 25) ? 100 : 0, p == 0, 1'b0);
        for (int i = 0; i < n; i++) beat(smp[i], i == 0, i == n - 1);
        @(negedge clk);
        data_in_valid         = 1'b0;
        data_in_startofpacket = 1'b0;
        data_in_endofpacket   = 1'b0;
    endtask

    task automatic check_emit(input int bp, input bit offer);
        int t;
        if (offer) begin
            data_in_valid         = 1'b1;
            data_in_startofpacket = 1'b1;
            data_in_data          = '0;
        end
        if (exp_n == 0) begin
            chk("nocl_valid", 32'(cl_valid), 32'd0);
            chk("nocl_done", 32'(frame_done), 32'd1);
        end else begin
            chk("first_valid_latency", 32'(cl_valid), 32'd1);
            for (int r = 0; r < exp_n; r++) begin
                t = 0;
                while (!cl_valid && t < 20) begin
                    @(negedge clk);
                    t++;
                end
                chk("rec_valid", 32'(cl_valid), 32'd1);
                chk("rec_left", 32'(cl_left), 32'(exp_l[r]));
                chk("rec_right", 32'(cl_right), 32'(exp_r[r]));
                chk("rec_sum", {7'd0, cl_sum}, sum_bits(exp_s[r]));
                chk("rec_index", 32'(cl_index), 32'(r));
                chk("rec_last", 32'(cl_last), 32'(r == exp_n - 1));
                chk("emit_in_ready", 32'(data_in_ready), 32'd0);
                for (int k = 0; k < bp; k++) begin
                    @(negedge clk);
                    chk("hold_valid", 32'(cl_valid), 32'd1);
                    chk("hold_left", 32'(cl_left), 32'(exp_l[r]));
                    chk("hold_right", 32'(cl_right), 32'(exp_r[r]));
                    chk("hold_sum", {7'd0, cl_sum}, sum_bits(exp_s[r]));
                    chk("hold_in_ready", 32'(data_in_ready), 32'd0);
                end
                if (r == exp_n - 1) begin
                    data_in_valid         = 1'b0;
                    data_in_startofpacket = 1'b0;
                end
                cl_ready = 1'b1;
                @(negedge clk);
                cl_ready = 1'b0;
            end
            chk("done_pulse", 32'(frame_done), 32'd1);
            chk("done_no_valid", 32'(cl_valid), 32'd0);
        end
        chk("n_clusters", 32'(n_clusters), 32'(exp_n));
        chk("cl_overflow", 32'(cl_overflow), 32'(exp_ovf));
        chk("frame_err", 32'(frame_err), 32'(exp_err));
        @(negedge clk);
        chk("done_one_cycle", 32'(frame_done), 32'd0);
        chk("idle_ready", 32'(data_in_ready), 32'd1);
        chk("n_clusters_held", 32'(n_clusters), 32'(exp_n));
    endtask

    task automatic run_frame(input int n, input int thr, input int minsz,
                             input int bp, input int pre, input bit offer);
        threshold = thr[15:0];
        min_size  = minsz[8:0];
        model(n, thr, minsz, pre > 0);
        send_frame(n, pre);
        check_emit(bp, offer);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int thr, minsz, p;
        rst                   = 1'b1;
        data_in_data          = '0;
        data_in_valid         = 1'b0;
        data_in_startofpacket = 1'b0;
        data_in_endofpacket   = 1'b0;
        threshold             = '0;
        min_size              = '0;
        cl_ready              = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(data_in_ready), 32'd0);
        chk("rst_cl_valid", 32'(cl_valid), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_n_clusters", 32'(n_clusters), 32'd0);
        chk("rst_overflow", 32'(cl_overflow), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;

        // Single cluster
        fill(0);
        for (int i = 100; i <= 107; i++) smp[i] = 200;
        run_frame(CH_NUM, 54, 4, 0, 0, 1'b0);

        // Three clusters plus a short run that is dropped
        fill(0);
        for (int i = 10;  i <= 14;  i++) smp[i] = 100;
        for (int i = 50;  i <= 51;  i++) smp[i] = 100;
        for (int i = 200; i <= 209; i++) smp[i] = 100;
        for (int i = 300; i <= 305; i++) smp[i] = 60;
        run_frame(CH_NUM, 54, 3, 0, 0, 1'b0);

        // Backpressure on the same frame with a SOP offered during emit
        run_frame(CH_NUM, 54, 3, 5, 0, 1'b1);

        // Overflow: six qualifying runs
        fill(0);
        for (int k = 0; k < 6; k++)
            for (int i = 0; i < 4; i++) smp[10 + 20 * k + i] = 100;
        run_frame(CH_NUM, 54, 1, 0, 0, 1'b0);

        // Edge channels, negative threshold and data
        fill(-20);
        for (int i = 0;   i <= 3;   i++) smp[i] = 5;
        for (int i = 316; i <= 319; i++) smp[i] = -5;
        run_frame(CH_NUM, -10, 2, 0, 0, 1'b0);

        // All at or below threshold (equal counts as not above)
        fill(54);
        run_frame(CH_NUM, 54, 1, 0, 0, 1'b0);

        // min_size 0 behaves as 1: isolated single channels qualify
        fill(0);
        smp[5] = 9; smp[7] = 9; smp[9] = 100;
        run_frame(CH_NUM, 8, 0, 0, 0, 1'b0);

        // Short frame
        fill(0);
        for (int i = 40; i <= 45; i++) smp[i] = 300;
        run_frame(200, 54, 2, 0, 0, 1'b0);

        // SOP mid-frame at channel 150 restarts the frame
        fill(0);
        for (int i = 100; i <= 107; i++) smp[i] = 200;
        run_frame(CH_NUM, 54, 4, 0, 150, 1'b0);

        // Reset during emit
        threshold = 16'd54;
        min_size  = 9'd4;
        send_frame(CH_NUM, 0);
        chk("pre_rst_valid", 32'(cl_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmid_cl_valid", 32'(cl_valid), 32'd0);
        chk("rstmid_in_ready", 32'(data_in_ready), 32'd0);
        chk("rstmid_n_clusters", 32'(n_clusters), 32'd0);
        chk("rstmid_left", 32'(cl_left), 32'd0);
        chk("rstmid_sum", {7'd0, cl_sum}, 32'd0);
        chk("rstmid_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_no_valid", 32'(cl_valid), 32'd0);
            chk("post_rst_no_done", 32'(frame_done), 32'd0);
        end

        // Random frames
        for (int f = 0; f < 8; f++) begin
            thr   = int'($urandom_range(0, 8000)) - 4000;
            minsz = int'($urandom_range(0, 5));
            p = 0;
            while (p < CH_NUM) begin
                if ($urandom_range(0, 39) == 0) begin
                    for (int k = int'($urandom_range(1, 8)); k > 0 && p < CH_NUM; k--) begin
                        smp[p] = thr + 1 + int'($urandom_range(0, 3000));
                        p++;
                    end
                end else begin
                    smp[p] = thr - int'($urandom_range(0, 3000));
                    p++;
                end
            end
            run_frame(CH_NUM, thr, minsz, int'($urandom_range(0, 2)), 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
